sdram_cmd_arbiter: RTL and testbench

//  Owns the SDRAM command/address pins. Sits downstream of the init sequencer, the auto-refresh

---
 rtl/sdram_cmd_arbiter.sv | 135 +++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - SDRAM command/address pin owner: init, auto-refresh and r/w arbitration
// Registered pins; refresh wins over r/w but never preempts an active r/w burst.
module sdram_cmd_arbiter #(
  parameter int SDRAMLINE = 2048,
  parameter int BAW       = 2,
  parameter int MAXWAIT   = 16,
  localparam int ADDRW    = $clog2(SDRAMLINE)
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic [3:0]       InitCmd,
  input  logic [ADDRW-1:0] InitAddr,
  input  logic             InitDone,
  input  logic             ArefReq,
  input  logic [3:0]       ArefCmd,
  input  logic [ADDRW-1:0] ArefMode,
  input  logic             ArefDone,
  input  logic             RwReq,
  input  logic [3:0]       RwCmd,
  input  logic [ADDRW-1:0] RwAddr,
  input  logic [BAW-1:0]   RwBa,
  input  logic             RwDone,
  output logic             RwGnt,
  output logic             SdramGetS,
  output logic             ArefLate,
  output logic [3:0]       SdramCmd,
  output logic [ADDRW-1:0] SdramAddr,
  output logic [BAW-1:0]   SdramBa
);

  localparam int CW = $clog2(MAXWAIT + 1) + 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAXWAIT);
  localparam logic [CW-1:0] WAIT_SAT   = '1;
  localparam logic [3:0]    CMD_NOP    = 4'b0111;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_AREF = 2'd2,
    ST_RW   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [BAW-1:0]   ba_q, ba_d;
  logic             gets_q, gets_d;
  logic             late_q, late_d;
  logic [CW-1:0]    wait_q, wait_d;

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q <= ST_INIT;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      gets_q  <= 1'b0;
      late_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      gets_q  <= gets_d;
      late_q  <= late_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    ba_d    = '0;
    gets_d  = 1'b0;
    wait_d  = wait_q;
    late_d  = late_q;

    // The cycle a source finishes drives NOP, giving one idle bubble on the pins.
    case (state_q)
      ST_INIT: begin
        cmd_d  = InitCmd;
        addr_d = InitAddr;
        if (InitDone) begin
          state_d = ST_IDLE;
          gets_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (ArefReq) begin
          state_d = ST_AREF;
        end else if (RwReq) begin
          state_d = ST_RW;
        end
      end
      ST_AREF: begin
        if (ArefDone) begin
          state_d = ST_IDLE;
        end else begin
          cmd_d  = ArefCmd;
          addr_d = ArefMode;
        end
      end
      ST_RW: begin
        if (RwDone) begin
          state_d = ST_IDLE;
        end else begin
          cmd_d  = RwCmd;
          addr_d = RwAddr;
          ba_d   = RwBa;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (state_q != ST_AREF && state_d == ST_AREF) begin
      wait_d = '0;
    end else if (ArefReq && state_q != ST_AREF && wait_q != WAIT_SAT) begin
      wait_d = wait_q + CW'(1);
    end

    if (wait_d > WAIT_LIMIT) begin
      late_d = 1'b1;
    end
  end

  assign RwGnt     = (state_q == ST_RW) && !Rest;
  assign SdramGetS = gets_q;
  assign ArefLate  = late_q;
  assign SdramCmd  = cmd_q;
  assign SdramAddr = addr_q;
  assign SdramBa   = ba_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb/tb_sdram_cmd_arbiter.sv - directed table and sequence checks for sdram_cmd_arbiter
module tb_sdram_cmd_arbiter;

  localparam int ADDRW = 11;
  localparam int BAW   = 2;

  localparam logic [3:0]       C_NOP  = 4'b0111;
  localparam logic [3:0]       C_INIT = 4'b0010;
  localparam logic [3:0]       C_AREF = 4'b0001;
  localparam logic [3:0]       C_PRE  = 4'b0010;
  localparam logic [3:0]       C_RW   = 4'b0100;
  localparam logic [ADDRW-1:0] A_INIT = 11'h055;
  localparam logic [ADDRW-1:0] A_AREF = 11'h400;
  localparam logic [ADDRW-1:0] A_RW   = 11'h123;
  localparam logic [BAW-1:0]   B_RW   = 2'd2;

  logic             Clk = 1'b0;
  logic             Rest;
  logic [3:0]       InitCmd;
  logic [ADDRW-1:0] InitAddr;
  logic             InitDone;
  logic             ArefReq;
  logic [3:0]       ArefCmd;
  logic [ADDRW-1:0] ArefMode;
  logic             ArefDone;
  logic             RwReq;
  logic [3:0]       RwCmd;
  logic [ADDRW-1:0] RwAddr;
  logic [BAW-1:0]   RwBa;
  logic             RwDone;
  logic             RwGnt;
  logic             SdramGetS;
  logic             ArefLate;
  logic [3:0]       SdramCmd;
  logic [ADDRW-1:0] SdramAddr;
  logic [BAW-1:0]   SdramBa;

  sdram_cmd_arbiter #(.SDRAMLINE(2048), .BAW(BAW), .MAXWAIT(16)) dut (
    .Clk(Clk), .Rest(Rest),
    .InitCmd(InitCmd), .InitAddr(InitAddr), .InitDone(InitDone),
    .ArefReq(ArefReq), .ArefCmd(ArefCmd), .ArefMode(ArefMode), .ArefDone(ArefDone),
    .RwReq(RwReq), .RwCmd(RwCmd), .RwAddr(RwAddr), .RwBa(RwBa), .RwDone(RwDone),
    .RwGnt(RwGnt), .SdramGetS(SdramGetS), .ArefLate(ArefLate),
    .SdramCmd(SdramCmd), .SdramAddr(SdramAddr), .SdramBa(SdramBa)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic             rst, idone, areq, adone, rreq, rdone;
    logic [3:0]       acmd;
    logic [3:0]       exp_cmd;
    logic [ADDRW-1:0] exp_addr;
    logic [BAW-1:0]   exp_ba;
    logic             exp_gnt, exp_gets, exp_late;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, idone, areq, adone, rreq, rdone, input logic [3:0] acmd,
                     input logic [3:0] ecmd, input logic [ADDRW-1:0] eaddr,
                     input logic [BAW-1:0] eba, input logic egnt, egets, elate);
    vec_t v;
    v.rst = rst; v.idone = idone; v.areq = areq; v.adone = adone;
    v.rreq = rreq; v.rdone = rdone; v.acmd = acmd;
    v.exp_cmd = ecmd; v.exp_addr = eaddr; v.exp_ba = eba;
    v.exp_gnt = egnt; v.exp_gets = egets; v.exp_late = elate;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, idone, areq, adone, rreq, rdone);
    Rest = rst; InitDone = idone; ArefReq = areq; ArefDone = adone;
    RwReq = rreq; RwDone = rdone;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic pins(input string name, input logic [3:0] cmd, input logic [ADDRW-1:0] addr,
                      input logic [BAW-1:0] ba, input logic gnt);
    chk({name, "_cmd"}, 16'(SdramCmd), 16'(cmd));
    chk({name, "_addr"}, 16'(SdramAddr), 16'(addr));
    chk({name, "_ba"}, 16'(SdramBa), 16'(ba));
    chk({name, "_gnt"}, 16'(RwGnt), 16'(gnt));
  endtask

  // From IDLE with a refresh pending: enter AREF, one refresh command, then done.
  task automatic do_aref(input string name);
    drive(0, 1, 1, 0, 1, 0); tick;
    pins({name, "_enter"}, C_NOP, '0, '0, 0);
    drive(0, 1, 0, 0, 1, 0); tick;
    pins({name, "_cmd"}, C_AREF, A_AREF, '0, 0);
    drive(0, 1, 0, 1, 1, 0); tick;
    pins({name, "_exit"}, C_NOP, '0, '0, 0);
  endtask

  initial begin
    InitCmd = C_INIT; InitAddr = A_INIT;
    ArefCmd = C_AREF; ArefMode = A_AREF;
    RwCmd = C_RW; RwAddr = A_RW; RwBa = B_RW;
    drive(1, 0, 0, 0, 0, 0);

    //   rst idn arq adn rrq rdn acmd     ecmd    eaddr   eba   gnt gts late
    add(1, 0, 0, 0, 0, 0, C_AREF, C_NOP,  '0,     '0,   0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 0, 0, 0, C_AREF, C_INIT, A_INIT, '0,   0, 0, 0);
    add(0, 1, 0, 0, 0, 0, C_AREF, C_INIT, A_INIT, '0,   0, 1, 0);
    add(0, 1, 0, 0, 0, 0, C_AREF, C_NOP,  '0,     '0,   0, 0, 0);
    add(0, 1, 1, 0, 1, 0, C_AREF, C_NOP,  '0,     '0,   0, 0, 0);
    add(0, 1, 1, 0, 1, 0, C_AREF, C_AREF, A_AREF, '0,   0, 0, 0);
    add(0, 1, 0, 0, 1, 0, C_PRE,  C_PRE,  A_AREF, '0,   0, 0, 0);
    add(0, 1, 0, 1, 1, 0, C_AREF, C_NOP,  '0,     '0,   0, 0, 0);
    add(0, 1, 0, 0, 1, 0, C_AREF, C_NOP,  '0,     '0,   1, 0, 0);
    add(0, 1, 0, 1, 1, 0, C_AREF, C_RW,   A_RW,   B_RW, 1, 0, 0);
    add(0, 1, 0, 1, 1, 0, C_AREF, C_RW,   A_RW,   B_RW, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, C_AREF, C_NOP,  '0,     '0,   0, 0, 0);
    add(0, 1, 0, 1, 0, 0, C_AREF, C_NOP,  '0,     '0,   0, 0, 0);
    add(0, 1, 0, 0, 1, 0, C_AREF, C_NOP,  '0,     '0,   1, 0, 0);
    add(0, 1, 0, 0, 1, 0, C_AREF, C_RW,   A_RW,   B_RW, 1, 0, 0);

    @(negedge Clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].idone, vecs[i].areq, vecs[i].adone, vecs[i].rreq, vecs[i].rdone);
      ArefCmd = vecs[i].acmd;
      tick;
      pins($sformatf("v%0d", i), vecs[i].exp_cmd, vecs[i].exp_addr, vecs[i].exp_ba, vecs[i].exp_gnt);
      chk($sformatf("v%0d_gets", i), 16'(SdramGetS), 16'(vecs[i].exp_gets));
      chk($sformatf("v%0d_late", i), 16'(ArefLate), 16'(vecs[i].exp_late));
    end
    ArefCmd = C_AREF;

    // Refresh raised mid-burst waits for RwDone (11 waiting cycles, below the limit).
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 1, 0, 1, 0); tick;
      pins($sformatf("s3_hold%0d", k), C_RW, A_RW, B_RW, 1);
    end
    drive(0, 1, 1, 0, 1, 1); tick;
    pins("s3_done", C_NOP, '0, '0, 0);
    chk("s3_late_done", 16'(ArefLate), 16'(0));
    do_aref("s3_aref");
    chk("s3_late_after", 16'(ArefLate), 16'(0));
    drive(0, 1, 0, 0, 1, 0); tick;
    chk("s3_regnt", 16'(RwGnt), 16'(1));

    // Exactly MAXWAIT waiting cycles must not set ArefLate.
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, 1, 0, 1, 0); tick;
    end
    drive(0, 1, 1, 0, 1, 1); tick;
    chk("bnd16_late", 16'(ArefLate), 16'(0));
    do_aref("bnd_aref");
    chk("bnd16_late_after", 16'(ArefLate), 16'(0));
    drive(0, 1, 0, 0, 1, 0); tick;
    chk("s4_regnt", 16'(RwGnt), 16'(1));

    // Long burst: ArefLate rises on the 17th waiting cycle and is sticky.
    for (int k = 1; k <= 20; k++) begin
      drive(0, 1, 1, 0, 1, 0); tick;
      chk($sformatf("s4_late_k%0d", k), 16'(ArefLate), 16'(k >= 17));
    end
    drive(0, 1, 1, 0, 1, 1); tick;
    do_aref("s4_aref");
    chk("s4_late_sticky", 16'(ArefLate), 16'(1));
    drive(0, 1, 0, 0, 1, 0); tick;
    chk("s4_late_rw", 16'(ArefLate), 16'(1));
    pins("s4_rw", C_NOP, '0, '0, 1);

    // Reset in the middle of RW.
    drive(0, 1, 0, 0, 1, 0); tick;
    pins("s5_pre", C_RW, A_RW, B_RW, 1);
    drive(1, 1, 0, 0, 1, 0); tick;
    pins("s5_rst", C_NOP, '0, '0, 0);
    chk("s5_late", 16'(ArefLate), 16'(0));
    chk("s5_gets", 16'(SdramGetS), 16'(0));
    drive(0, 0, 0, 0, 1, 0); tick;
    pins("s5_init", C_INIT, A_INIT, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
